// File: rtl/sdft_bin_dumper_if.sv
// Interface between the bin dumper, the SDFT core and the bin BRAM.
// The master modport is the dumper side.
interface sdft_bin_dumper_if #(
  parameter int unsigned FREQ_BINS = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OUT_W     = 16
);
  localparam int unsigned A_W = $clog2(FREQ_BINS) + 1;

  logic [7:0]               adc;
  logic [7:0]               sample;
  logic                     fft_ready;
  logic                     fft_start;
  logic                     fft_read;
  logic signed [DATA_W-1:0] bin_real;
  logic signed [DATA_W-1:0] bin_imag;
  logic                     bram_w_en;
  logic [A_W-1:0]           bram_w_addr;
  logic [OUT_W-1:0]         bram_w_data;
  logic                     dump_done;

  modport master (
    input  adc, fft_ready, bin_real, bin_imag,
    output sample, fft_start, fft_read, bram_w_en, bram_w_addr, bram_w_data, dump_done
  );

  modport slave (
    output adc, fft_ready, bin_real, bin_imag,
    input  sample, fft_start, fft_read, bram_w_en, bram_w_addr, bram_w_data, dump_done
  );
endinterface

// File: rtl/sdft_bin_dumper.sv
// Feeds ADC samples to the SDFT and periodically dumps clamped |bin|^2 into the bar BRAM.
// Optional peak-hold with decay: define SDFT_BIN_DUMPER_PEAK_HOLD_EN.
module sdft_bin_dumper #(
  parameter int unsigned FREQ_BINS     = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned UPDATE_PERIOD = 2048,
  parameter int unsigned SHIFT         = 8,
  parameter int unsigned CLAMP_MAX     = 640
`ifdef SDFT_BIN_DUMPER_PEAK_HOLD_EN
  ,
  parameter int unsigned DECAY         = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  sdft_bin_dumper_if.master     bus
);
  localparam int unsigned K_W   = $clog2(FREQ_BINS);
  localparam int unsigned CNT_W = $clog2(UPDATE_PERIOD);
  localparam int unsigned SQ_W  = 2 * DATA_W;
  localparam int unsigned SUM_W = SQ_W + 1;

  typedef enum logic [1:0] {
    ST_SAMPLE = 2'd0,
    ST_DUMP   = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [K_W-1:0]     k_q;
  logic [7:0]         sample_q;
  logic               start_q;
  logic               read_q;
  logic               pend_q;
  logic               v1_q;
  logic               v2_q;
  logic [SQ_W-1:0]    sq_re_q;
  logic [SQ_W-1:0]    sq_im_q;
  logic               w_en_q;
  logic [K_W:0]       w_addr_q;
  logic [OUT_W-1:0]   w_data_q;
  logic               done_q;

  logic signed [SQ_W-1:0] re_sq_d;
  logic signed [SQ_W-1:0] im_sq_d;
  logic [SUM_W-1:0]       sum_d;
  logic [SUM_W-1:0]       shf_d;
  logic [OUT_W-1:0]       mag_d;
  logic [OUT_W-1:0]       wdata_d;

  // Squares of the bin presented the cycle after fft_read; always non-negative.
  assign re_sq_d = SQ_W'(bus.bin_real) * SQ_W'(bus.bin_real);
  assign im_sq_d = SQ_W'(bus.bin_imag) * SQ_W'(bus.bin_imag);

`ifdef SDFT_BIN_DUMPER_PEAK_HOLD_EN
  logic [OUT_W-1:0] held_q [FREQ_BINS];
  logic [OUT_W-1:0] held_cur_d;
  logic [OUT_W-1:0] decayed_d;
`endif

  // Sum, scale and saturate; the extra sum bit keeps the (-max,-max) corner exact.
  always_comb begin
    sum_d = SUM_W'(sq_re_q) + SUM_W'(sq_im_q);
    shf_d = sum_d >> SHIFT;
    mag_d = (shf_d > SUM_W'(CLAMP_MAX)) ? OUT_W'(CLAMP_MAX) : OUT_W'(shf_d);
`ifdef SDFT_BIN_DUMPER_PEAK_HOLD_EN
    held_cur_d = held_q[k_q];
    decayed_d  = (held_cur_d > OUT_W'(DECAY)) ? (held_cur_d - OUT_W'(DECAY)) : '0;
    wdata_d    = (mag_d > decayed_d) ? mag_d : decayed_d;
`else
    wdata_d    = mag_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_SAMPLE;
      cnt_q    <= '0;
      k_q      <= '0;
      sample_q <= '0;
      start_q  <= 1'b0;
      read_q   <= 1'b0;
      pend_q   <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      sq_re_q  <= '0;
      sq_im_q  <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      done_q   <= 1'b0;
`ifdef SDFT_BIN_DUMPER_PEAK_HOLD_EN
      for (int unsigned i = 0; i < FREQ_BINS; i++) held_q[i] <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      read_q  <= 1'b0;
      w_en_q  <= 1'b0;
      done_q  <= 1'b0;
      v1_q    <= read_q;
      v2_q    <= v1_q;
      if (v1_q) begin
        sq_re_q <= re_sq_d;
        sq_im_q <= im_sq_d;
      end

      case (state_q)
        ST_SAMPLE: begin
          if (bus.fft_ready) begin
            sample_q <= bus.adc;
            start_q  <= 1'b1;
            if (cnt_q == CNT_W'(UPDATE_PERIOD - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_DUMP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        ST_DUMP: begin
          // One read in flight at a time; the write retires it.
          if (bus.fft_ready && !pend_q) begin
            read_q <= 1'b1;
            pend_q <= 1'b1;
          end
          if (v2_q) begin
            w_en_q   <= 1'b1;
            w_addr_q <= {1'b0, k_q};
            w_data_q <= wdata_d;
            pend_q   <= 1'b0;
`ifdef SDFT_BIN_DUMPER_PEAK_HOLD_EN
            held_q[k_q] <= wdata_d;
`endif
            if (k_q == K_W'(FREQ_BINS - 1)) begin
              k_q     <= '0;
              state_q <= ST_DONE;
            end else begin
              k_q <= k_q + K_W'(1);
            end
          end
        end

        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_SAMPLE;
        end

        default: state_q <= ST_SAMPLE;
      endcase
    end
  end

  assign bus.sample      = sample_q;
  assign bus.fft_start   = start_q;
  assign bus.fft_read    = read_q;
  assign bus.bram_w_en   = w_en_q;
  assign bus.bram_w_addr = w_addr_q;
  assign bus.bram_w_data = w_data_q;
  assign bus.dump_done   = done_q;
endmodule

// File: tb/tb_sdft_bin_dumper.sv
// Directed bench for sdft_bin_dumper with a small SDFT read model and an event monitor.
module tb_sdft_bin_dumper;
  localparam int unsigned FB = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 16;
  localparam int unsigned UP = 4;
  localparam int unsigned SH = 8;
  localparam int unsigned CM = 640;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic signed [DW-1:0] tbl_re [FB];
  logic signed [DW-1:0] tbl_im [FB];
  logic [1:0]           rd_idx;

  int rd_q [$];
  int wr_cyc [$];
  int wr_addr [$];
  int wr_data [$];
  int done_q [$];
  int n_start = 0;
  int n_both = 0;

  sdft_bin_dumper_if #(.FREQ_BINS(FB), .DATA_W(DW), .OUT_W(OW)) bus ();

  sdft_bin_dumper #(
    .FREQ_BINS(FB), .DATA_W(DW), .OUT_W(OW), .UPDATE_PERIOD(UP),
    .SHIFT(SH), .CLAMP_MAX(CM)
`ifdef SDFT_BIN_DUMPER_PEAK_HOLD_EN
    , .DECAY(4)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SDFT model: each fft_read presents the next table entry one cycle later.
  always @(posedge clk) begin
    if (reset) begin
      rd_idx <= 2'd0;
    end else if (bus.fft_read) begin
      bus.bin_real <= tbl_re[rd_idx];
      bus.bin_imag <= tbl_im[rd_idx];
      rd_idx       <= rd_idx + 2'd1;
    end
  end

  always @(negedge clk) begin
    if (bus.fft_read) rd_q.push_back(cyc);
    if (bus.bram_w_en) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(bus.bram_w_addr));
      wr_data.push_back(int'(bus.bram_w_data));
    end
    if (bus.dump_done) done_q.push_back(cyc);
    if (bus.fft_start) n_start++;
    if (bus.fft_start && bus.fft_read) n_both++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_tbl(input int r0, i0, r1, i1, r2, i2, r3, i3);
    tbl_re[0] = DW'(r0); tbl_im[0] = DW'(i0);
    tbl_re[1] = DW'(r1); tbl_im[1] = DW'(i1);
    tbl_re[2] = DW'(r2); tbl_im[2] = DW'(i2);
    tbl_re[3] = DW'(r3); tbl_im[3] = DW'(i3);
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done_q.size() > n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.fft_ready = 1'b1;
    bus.adc       = 8'h55;
    load_tbl(16, 0, 0, 32, -16, -16, 100, 100);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.sample, bus.fft_start, bus.fft_read, bus.bram_w_en, bus.bram_w_addr,
           bus.bram_w_data, bus.dump_done} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: cycle %0d start=%b read=%b wen=%b sample=%h, required all zero",
                 i, bus.fft_start, bus.fft_read, bus.bram_w_en, bus.sample);
      end
    end
    checks++;
    if (n_start != 0) begin
      failures++;
      $display("FAIL reset_no_start: got %0d starts, required 0", n_start);
    end
    bus.adc = 8'h10;
    reset   = 1'b0;
    tick();
    checks++;
    if (bus.fft_start !== 1'b1 || bus.sample !== 8'h10) begin
      failures++;
      $display("FAIL first_start: start=%b sample=%h, required 1/10", bus.fft_start, bus.sample);
    end
  endtask

  task automatic test_sampling();
    logic [7:0] exp_s;
    for (int i = 1; i < 4; i++) begin
      exp_s   = 8'(16 * (i + 1));
      bus.adc = exp_s;
      tick();
      checks++;
      if (bus.fft_start !== 1'b1 || bus.sample !== exp_s) begin
        failures++;
        $display("FAIL sample_%0d: start=%b sample=%h, required 1/%h", i, bus.fft_start, bus.sample, exp_s);
      end
    end
    bus.adc = 8'h99;
    tick();
    checks++;
    if (bus.fft_read !== 1'b1 || bus.fft_start !== 1'b0) begin
      failures++;
      $display("FAIL first_read: read=%b start=%b, required 1/0", bus.fft_read, bus.fft_start);
    end
  endtask

  task automatic test_dump();
    int rb = rd_q.size() - 1;
    int wb = wr_cyc.size();
    int db = done_q.size();
    int exp_d [4] = '{1, 4, 2, 78};
    bit ok;
    wait_done(db, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL dump_timeout: no dump_done, required one");
    end
    checks++;
    if (wr_cyc.size() - wb != 4) begin
      failures++;
      $display("FAIL dump_count: got %0d writes, required 4", wr_cyc.size() - wb);
    end
    for (int i = 0; i < 4; i++) begin
      if (wb + i < wr_cyc.size() && rb + i < rd_q.size()) begin
        checks++;
        if (wr_addr[wb+i] != i || wr_data[wb+i] != exp_d[i]) begin
          failures++;
          $display("FAIL dump_write_%0d: addr=%0d data=%0d, required %0d/%0d",
                   i, wr_addr[wb+i], wr_data[wb+i], i, exp_d[i]);
        end
        checks++;
        if (wr_cyc[wb+i] - rd_q[rb+i] != 3) begin
          failures++;
          $display("FAIL dump_latency_%0d: got %0d, required 3", i, wr_cyc[wb+i] - rd_q[rb+i]);
        end
      end
    end
    if (ok && wr_cyc.size() - wb == 4) begin
      checks++;
      if (done_q[db] - wr_cyc[wb+3] != 1) begin
        failures++;
        $display("FAIL done_latency: got %0d, required 1", done_q[db] - wr_cyc[wb+3]);
      end
    end
    checks++;
    if (n_start != 4) begin
      failures++;
      $display("FAIL no_start_in_dump: got %0d starts, required 4", n_start);
    end
  endtask

  task automatic test_clamp();
    int wb = wr_cyc.size();
    int db = done_q.size();
    int exp_d [4] = '{640, 1, 640, 511};
    bit ok;
    load_tbl(-32768, -32768, 0, -16, 400, 300, -362, 0);
    bus.adc = 8'hA5;
    tick();
    checks++;
    if (bus.fft_start !== 1'b1 || bus.sample !== 8'hA5) begin
      failures++;
      $display("FAIL resume_start: start=%b sample=%h, required 1/a5", bus.fft_start, bus.sample);
    end
    wait_done(db, ok);
    checks++;
    if (!ok || wr_cyc.size() - wb != 4) begin
      failures++;
      $display("FAIL clamp_count: got %0d writes, required 4", wr_cyc.size() - wb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[wb+i] != i || wr_data[wb+i] != exp_d[i]) begin
          failures++;
          $display("FAIL clamp_write_%0d: addr=%0d data=%0d, required %0d/%0d",
                   i, wr_addr[wb+i], wr_data[wb+i], i, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int wb = wr_cyc.size();
    int db = done_q.size();
    int exp_d [4] = '{1, 4, 2, 78};
    int c0;
    int bad = 0;
    bit ok = 1'b0;
    load_tbl(16, 0, 0, 32, -16, -16, 100, 100);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_cyc.size() > wb) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_first_write: no write seen, required one");
    end
    bus.fft_ready = 1'b0;
    c0 = cyc;
    repeat (10) tick();
    bus.fft_ready = 1'b1;
    foreach (rd_q[i]) if (rd_q[i] > c0 && rd_q[i] <= c0 + 10) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_no_read: got %0d reads while not ready, required 0", bad);
    end
    wait_done(db, ok);
    checks++;
    if (!ok || wr_cyc.size() - wb != 4) begin
      failures++;
      $display("FAIL stall_count: got %0d writes, required 4", wr_cyc.size() - wb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[wb+i] != i || wr_data[wb+i] != exp_d[i]) begin
          failures++;
          $display("FAIL stall_write_%0d: addr=%0d data=%0d, required %0d/%0d",
                   i, wr_addr[wb+i], wr_data[wb+i], i, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int rb = rd_q.size();
    int wc;
    int dc;
    int s0;
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd_q.size() >= rb + 2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_dump_reads: got %0d reads, required 2", rd_q.size() - rb);
    end
    reset = 1'b1;
    wc = wr_cyc.size();
    dc = done_q.size();
    repeat (2) tick();
    s0 = n_start;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.fft_start !== 1'b1 || bus.fft_read !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_sample_state: start=%b read=%b, required 1/0", bus.fft_start, bus.fft_read);
    end
    repeat (2) tick();
    checks++;
    if (wr_cyc.size() != wc || done_q.size() != dc) begin
      failures++;
      $display("FAIL mid_reset_no_write: got %0d writes %0d dones, required 0/0",
               wr_cyc.size() - wc, done_q.size() - dc);
    end
    rb = rd_q.size();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rd_q.size() > rb) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || n_start - s0 != 4) begin
      failures++;
      $display("FAIL mid_reset_restart: got %0d starts before read, required 4", n_start - s0);
    end
  endtask

  task automatic test_hold();
    int exp_d [3];
    int wb;
    int db;
    bit ok;
`ifdef SDFT_BIN_DUMPER_PEAK_HOLD_EN
    exp_d = '{100, 96, 92};
`else
    exp_d = '{100, 0, 0};
`endif
    reset = 1'b1;
    repeat (2) tick();
    load_tbl(160, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      wb = wr_cyc.size();
      db = done_q.size();
      wait_done(db, ok);
      load_tbl(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (!ok || wr_cyc.size() - wb != 4) begin
        failures++;
        $display("FAIL hold_count_%0d: got %0d writes, required 4", d, wr_cyc.size() - wb);
      end else if (wr_addr[wb] != 0 || wr_data[wb] != exp_d[d]) begin
        failures++;
        $display("FAIL hold_bin0_%0d: addr=%0d data=%0d, required 0/%0d", d, wr_addr[wb], wr_data[wb], exp_d[d]);
      end
    end
  endtask

  initial begin
    bus.fft_ready = 1'b1;
    bus.adc       = 8'h00;
    bus.bin_real  = '0;
    bus.bin_imag  = '0;
    test_reset();
    test_sampling();
    test_dump();
    test_clamp();
    test_stall();
    test_reset_mid_dump();
    test_hold();
    checks++;
    if (n_both != 0) begin
      failures++;
      $display("FAIL start_read_overlap: got %0d cycles with both, required 0", n_both);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdft_bin_dumper.md
Name: sdft_bin_dumper

Overview:
- Sits between the ADC/SDFT core and the frequency-bin BRAM that the VGA bar renderer reads.
- Feeds ADC samples into the SDFT core using a start/ready handshake.
- After every UPDATE_PERIOD accepted samples, reads all FREQ_BINS bins out in turn, computes re²+im², scales and clamps the result to screen width, and writes one BRAM word per bin.

Parameters:
- FREQ_BINS, 16, number of SDFT bins; power of two.
- DATA_W, 16, signed width of bin_real/bin_imag.
- OUT_W, 16, BRAM data width.
- UPDATE_PERIOD, 2048, accepted samples between bin dumps; power of two, ≥2.
- SHIFT, 8, right shift applied to the magnitude-squared sum.
- CLAMP_MAX, 640, saturation ceiling for written values (bar length in px).
- DECAY, 4, peak-hold decay per dump (only used with PEAK_HOLD_EN).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- adc  in  8  raw ADC sample.
- sample  out  8  registered sample presented to the SDFT.
- fft_ready  in  1  SDFT idle; may accept start or read.
- fft_start  out  1  one-cycle pulse; SDFT consumes sample.
- fft_read  out  1  one-cycle pulse; SDFT presents next bin.
- bin_real  in  DATA_W  signed real part; valid the cycle after fft_read.
- bin_imag  in  DATA_W  signed imaginary part; same timing as bin_real.
- bram_w_en  out  1  one-cycle write strobe.
- bram_w_addr  out  clog2(FREQ_BINS)+1  bin index; MSB always 0.
- bram_w_data  out  OUT_W  clamped magnitude.
- dump_done  out  1  one-cycle pulse after the last bin write.

Behaviour:
- Reset values:
  - sample=0, fft_start=0, fft_read=0, bram_w_en=0, bram_w_addr=0, bram_w_data=0, dump_done=0.
  - State=SAMPLE, sample counter=0, bin index=0, pipeline valids cleared.
- Reset mid-dump aborts with no further writes. A write already in flight is dropped.
- Handshake: fft_start and fft_read are asserted only in a cycle where fft_ready=1, and never both in the same cycle. The SDFT is assumed to drop ready the following cycle.
- SAMPLE state:
  - Each cycle with fft_ready=1: latch adc into sample and pulse fft_start in the same cycle (sample registered together with the start).
  - Increment the sample counter on each start.
  - On the start that brings the counter to UPDATE_PERIOD-1 → wraps to 0 and the state moves to DUMP.
- DUMP state:
  - Bin index k starts at 0.
  - When fft_ready=1 and no read is outstanding: pulse fft_read and mark the read outstanding. Stall indefinitely while fft_ready=0.
  - Cycle t = fft_read. In t+1, sample bin_real/bin_imag into square registers (unsigned, 2·DATA_W bits each).
  - Cycle t+2: sum the squares (2·DATA_W+1 bits, no overflow possible), then shift right by SHIFT. If the result > CLAMP_MAX, use CLAMP_MAX. Truncate to OUT_W.
  - Cycle t+3: bram_w_en=1, bram_w_addr=k, bram_w_data=result. Outstanding flag clears and k increments.
  - Latency from fft_read to write = 3 cycles. The next fft_read occurs no earlier than t+3.
  - After the k=FREQ_BINS-1 write: pulse dump_done in the next cycle, k wraps to 0, return to SAMPLE.
- No samples are started during DUMP; ADC data in that window is dropped.
- Edge case: bin = (-2^(DATA_W-1), -2^(DATA_W-1)) gives sum 2^(2·DATA_W-1), computed exactly before clamping.

Optional Feature:
- Macro: SDFT_BIN_DUMPER_PEAK_HOLD_EN.
- Defined:
  - An internal register per bin holds the last written value, reset to 0.
  - Written value = max(new, held − DECAY), with held − DECAY floored at 0. The held register updates on every write.
  - Same latency as without the feature; the max is folded into the t+2 stage.
- Undefined: no per-bin storage; the written value is the clamped magnitude only.

Test Plan:
- Reset: assert reset for 3 cycles with fft_ready=1 → all outputs 0, no fft_start during reset. First fft_start appears the cycle after reset deasserts.
- Sampling with UPDATE_PERIOD=4: fft_ready held 1, adc=0x10,0x20,0x30,0x40 → four fft_start pulses with sample following adc, then the first fft_read. No fifth fft_start before dump_done.
- Dump with FREQ_BINS=4, SHIFT=8:
  - Bins (16,0),(0,32),(-16,-16),(100,100) → writes addr0=1, addr1=4, addr2=2, addr3=78.
  - Each write comes 3 cycles after its fft_read; dump_done follows the last write by 1 cycle.
- Clamp: bin (-32768,-32768), SHIFT=8 → write CLAMP_MAX=640.
- Stall/reset: during dump drop fft_ready for 10 cycles → no fft_read meanwhile; writes resume in order. Assert reset mid-dump → no further bram_w_en, state returns to SAMPLE.
- PEAK_HOLD_EN, DECAY=4: bin0 magnitudes 100 then 0 then 0 → writes 100, 96, 92.
